uart_tx_buffered: RTL

Buffered UART transmitter that serialises bytes onto a single line as 8N1 frames: one start bit, 8 data bits LSB first, optional parity bit, one stop bit. It is the transmit counterpart of the team's UART receiver and uses the same `CLKS_PER_BIT` bit-timing convention. A small FIFO sits in front of the shifter so the host can queue bytes without polling per frame. It sits between host/CPU-side logic and the board TX pin.

---
 rtl/uart_tx_buffered.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: small circular FIFO feeding an 8N1 (or 8E1) serialiser.
// Define UART_TX_PARITY_EN to compile in an even-parity bit after data bit 7.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 2
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    input  logic               i_Tx_DV,
    input  logic [7:0]         i_Tx_Byte,
    output logic               o_Tx_Ready,
    output logic               o_Tx_Serial,
    output logic               o_Tx_Active,
    output logic               o_Tx_Done,
    output logic [FIFO_AW:0]   o_Fifo_Count,
    output logic [2:0]         o_Fsm_State
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0]    CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    CNT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] FIFO_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      clk_cnt_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic               serial_q;
    logic               active_q;
    logic               done_q;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;

    logic push;
    logic pop;
    logic fifo_empty;
    logic bit_end;

    // Handshake: a byte transfers on a rising edge where i_Tx_DV and o_Tx_Ready are both high.
    assign fifo_empty = (count_q == '0);
    assign o_Tx_Ready = (count_q != CNT_FULL);
    assign push       = i_Tx_DV && o_Tx_Ready;
    assign bit_end    = (clk_cnt_q == CNT_LAST);
    assign pop        = !fifo_empty &&
                        ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + FIFO_ONE;
        end else if (!push && pop) begin
            count_d = count_q - FIFO_ONE;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) mem_q[wr_ptr_q] <= i_Tx_Byte;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    serial_q  <= 1'b1;
                    active_q  <= 1'b0;
                    clk_cnt_q <= '0;
                    if (pop) begin
                        shift_q   <= mem_q[rd_ptr_q];
                        bit_idx_q <= '0;
                        serial_q  <= 1'b0;
                        active_q  <= 1'b1;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        serial_q  <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        // Leave on bit 7 without incrementing so the index never wraps.
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            serial_q <= ^shift_q;
                            state_q  <= S_PARITY;
`else
                            serial_q <= 1'b1;
                            state_q  <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            serial_q  <= shift_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        serial_q  <= 1'b1;
                        state_q   <= S_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        if (pop) begin
                            shift_q   <= mem_q[rd_ptr_q];
                            bit_idx_q <= '0;
                            serial_q  <= 1'b0;
                            state_q   <= S_START;
                        end else begin
                            serial_q <= 1'b1;
                            active_q <= 1'b0;
                            state_q  <= S_IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                        // Registered pulse lands on the final stop-bit cycle.
                        done_q    <= (clk_cnt_q == CNT_PRE);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Tx_Serial  = serial_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Done    = done_q;
    assign o_Fifo_Count = count_q;
    assign o_Fsm_State  = state_q;

endmodule
